// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter; issues one-cycle pulses when idle.
// Define UART_TX_BUF_OVF_EN to enable the sticky overflow flag.
module uart_tx_buffer #(
  parameter int data_bits     = 8,
  parameter int depth         = 16,
  parameter int start_timeout = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [data_bits-1:0]       wr_data_i,
  input  logic                       wr_en_i,
  input  logic                       tx_active_i,
  output logic [data_bits-1:0]       tx_data_o,
  output logic                       tx_data_vld_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(depth+1)-1:0] level_o,
  output logic                       overflow_o,
  input  logic                       ovf_clr_i
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);
  localparam int tw = (start_timeout > 1) ? $clog2(start_timeout) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  logic [data_bits-1:0] mem [depth];
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        rd_ptr;
  logic [cw-1:0]        count;
  logic [tw-1:0]        tmo;
  state_t               state;
  logic                 push;
  logic                 pop;

  assign full_o  = (count == cw'(depth));
  assign empty_o = (count == '0);
  assign level_o = count;

  assign push = wr_en_i && !full_o;
  assign pop  = (state == IDLE) && !empty_o && !tx_active_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tmo           <= '0;
      state         <= IDLE;
      tx_data_o     <= '0;
      tx_data_vld_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      tx_data_vld_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            tx_data_o     <= mem[rd_ptr];
            tx_data_vld_o <= 1'b1;
            tmo           <= '0;
            state         <= WAIT_START;
          end
        end
        WAIT_START: begin
          // A transmitter that never starts must not stall the queue.
          if (tx_active_i)                          state <= WAIT_DONE;
          else if (tmo == tw'(start_timeout - 1))   state <= IDLE;
          else                                      tmo   <= tmo + 1'b1;
        end
        WAIT_DONE: begin
          if (!tx_active_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_BUF_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    ovf_q <= 1'b0;
    else if (wr_en_i && full_o)   ovf_q <= 1'b1;
    else if (ovf_clr_i)           ovf_q <= 1'b0;
  end

  assign overflow_o = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr_i;
  assign overflow_o     = 1'b0;
`endif

endmodule
